// File: rtl/s444_misr_compactor.sv
// s444_misr_compactor
// Output-response compactor for the s444 BIST harness. It folds the core's
// six primary outputs into a multiple-input signature register (MISR). While
// the core's flip-flops flush, it discards a warm-up window of enabled cycles.
// At the end of a run it compares the signature against a golden value and
// presents a single registered go/no-go bit.

module s444_misr_compactor #(
    parameter int unsigned        SIG_W        = 16,
    parameter logic [SIG_W-1:0]   POLY         = 16'h1021,
    parameter logic [SIG_W-1:0]   SEED         = 16'h0000,
    parameter int unsigned        WARMUP       = 21,
    parameter int unsigned        NUM_PATTERNS = 256,
    parameter logic [SIG_W-1:0]   GOLDEN       = 16'h0000
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic             EN,
    input  logic [5:0]       RESP,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIG_W-1:0] SIG
);

    // One counter serves both phases, so it is sized for the longer one.
    localparam int unsigned CNT_MAX = (WARMUP > NUM_PATTERNS) ? WARMUP : NUM_PATTERNS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts. WARM is never entered when WARMUP is 0, so its terminal
    // value is unused in that case.
    localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
    localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARM    = 2'd1,
        ST_COMPACT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // A run starts in WARM. With no warm-up window it goes straight to COMPACT.
    localparam state_t RUN_ENTRY = (WARMUP > 0) ? ST_WARM : ST_COMPACT;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               pass_q, pass_d;

    logic [SIG_W-1:0]   resp_ext;
    logic [SIG_W-1:0]   misr_next;
    logic               warm_last;
    logic               comp_last;

    // Zero-extend the six core outputs to the signature width.
    always_comb begin
        resp_ext      = '0;
        resp_ext[5:0] = RESP;
    end

    // Per-bit MISR step: shift left, add feedback at the polynomial taps, and
    // fold in the response bit.
    generate
        for (genvar gi = 0; gi < SIG_W; gi++) begin : g_misr
            if (gi == 0) begin : g_lsb
                assign misr_next[gi] = (POLY[gi] & sig_q[SIG_W-1]) ^ resp_ext[gi];
            end else begin : g_bit
                assign misr_next[gi] = sig_q[gi-1] ^ (POLY[gi] & sig_q[SIG_W-1]) ^ resp_ext[gi];
            end
        end
    endgenerate

    assign warm_last = (cnt_q == WARM_LAST);
    assign comp_last = (cnt_q == COMP_LAST);

    // State register plus datapath flops. Reset has priority over everything.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sig_q   <= SEED;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic. START is honoured only when no run is in progress.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = RUN_ENTRY;
                end
            end
            ST_WARM: begin
                if (EN && warm_last) begin
                    state_d = ST_COMPACT;
                end
            end
            ST_COMPACT: begin
                if (EN && comp_last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter, signature and verdict updates. With EN low they all hold.
    always_comb begin
        cnt_d  = cnt_q;
        sig_d  = sig_q;
        pass_d = pass_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    sig_d  = SEED;
                    cnt_d  = '0;
                    pass_d = 1'b0;
                end
            end
            ST_WARM: begin
                if (EN) begin
                    cnt_d = warm_last ? '0 : cnt_q + CNT_W'(1);
                end
            end
            ST_COMPACT: begin
                if (EN) begin
                    sig_d = misr_next;
                    cnt_d = comp_last ? '0 : cnt_q + CNT_W'(1);
                    // The verdict is taken from the final signature on the
                    // edge that enters DONE, so it is coherent with DONE.
                    if (comp_last) begin
                        pass_d = (misr_next == GOLDEN);
                    end
                end
            end
            default: begin
                cnt_d  = '0;
                sig_d  = SEED;
                pass_d = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so RESP cannot reach them combinationally.
    always_comb begin
        BUSY = (state_q == ST_WARM) || (state_q == ST_COMPACT);
        DONE = (state_q == ST_DONE);
        PASS = pass_q && (state_q == ST_DONE);
        SIG  = sig_q;
    end

endmodule
